// File: rtl/main_result_buffer.sv
// Captures {regime,y} on each busy falling edge of `main` into a small FWFT FIFO.
// Optional MAIN_RESULT_BUFFER_DROPCNT_EN adds a saturating drop counter output.
module main_result_buffer #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  y,
  input  logic [1:0]    regime,
  input  logic          b,
  input  logic          active,
  input  logic          ovf_clr,
  output logic [W-1:0]  dout_y,
  output logic [1:0]    dout_reg,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          ovf
`ifdef MAIN_RESULT_BUFFER_DROPCNT_EN
  ,
  output logic [7:0]    drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [W+1:0]  mem [DEPTH];
  logic [AW-1:0] wptr_reg, rptr_reg;
  logic [CW-1:0] count_reg;
  logic          b_q;
  logic          ovf_reg;
  logic          cap, pop, wr, drop;

  assign full       = (count_reg == CW'(DEPTH));
  assign dout_valid = (count_reg != '0);
  assign count      = count_reg;
  assign ovf        = ovf_reg;

  assign cap  = b_q & ~b & active;
  assign pop  = dout_valid & dout_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign wr   = cap & (~full | pop);
  assign drop = cap & full & ~pop;

  // Head is read combinationally so the first entry falls through immediately.
  assign dout_y   = dout_valid ? mem[rptr_reg][W-1:0] : '0;
  assign dout_reg = dout_valid ? mem[rptr_reg][W+1:W] : '0;

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr_reg] <= {regime, y};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      b_q       <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      b_q <= b;
      if (wr) begin
        wptr_reg <= wptr_reg + AW'(1);
      end
      if (pop) begin
        rptr_reg <= rptr_reg + AW'(1);
      end
      case ({wr, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        ovf_reg <= 1'b1;
      end else if (ovf_clr) begin
        ovf_reg <= 1'b0;
      end
    end
  end

`ifdef MAIN_RESULT_BUFFER_DROPCNT_EN
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_reg <= '0;
    end else if (drop) begin
      if (drop_cnt_reg != 8'hff) begin
        drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
    end else if (ovf_clr) begin
      drop_cnt_reg <= '0;
    end
  end

  assign drop_cnt = drop_cnt_reg;
`endif

endmodule
